// File: rtl/ladner64_mp_add_seq_if.sv
// Request/response bundle for the multi-precision add/subtract sequencer.
// The requester uses the master view; the sequencer uses the slave view.
interface ladner64_mp_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int W = 64 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/ladner64_mp_add_seq.sv
// Multi-precision add/subtract sequencer: one 64-bit limb per cycle through
// a shared Ladner-Fischer adder, least significant limb first, carry kept
// in a register between limbs. Also holds the 64-bit adder itself.

// 64-bit Ladner-Fischer parallel-prefix adder with carry-in.
module top_module_ladner64 (
  output logic [63:0] s,
  output logic        cout,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin
);
  // Prefix tree: at level l every bit whose bit l is set combines with the
  // last bit of the preceding 2^l block. The carry-in is folded into bit 0.
  function automatic logic [64:0] lf_add(input logic [63:0] x,
                                         input logic [63:0] y,
                                         input logic        c);
    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] g_n;
    logic [63:0] p_n;
    logic [63:0] hp;
    int          j;
    hp   = x ^ y;
    g    = x & y;
    p    = hp;
    g[0] = g[0] | (p[0] & c);
    for (int l = 0; l < 6; l++) begin
      for (int i = 0; i < 64; i++) begin
        j = ((i >> l) << l) - 1;
        if (((i >> l) & 1) == 1) begin
          g_n[6'(i)] = g[6'(i)] | (p[6'(i)] & g[6'(j)]);
          p_n[6'(i)] = p[6'(i)] & p[6'(j)];
        end else begin
          g_n[6'(i)] = g[6'(i)];
          p_n[6'(i)] = p[6'(i)];
        end
      end
      g = g_n;
      p = p_n;
    end
    return {g[63], hp ^ {g[62:0], c}};
  endfunction

  // Sum and carry-out straight from the prefix network.
  always_comb begin
    {cout, s} = lf_add(a, b, cin);
  end
endmodule

module ladner64_mp_add_seq #(
  parameter int WORDS = 4
) (
  input logic                  clk,
  input logic                  rst,
  ladner64_mp_add_seq_if.slave bus
);
  localparam int IW = $clog2(WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic [WORDS-1:0][63:0] a_q, a_d;
  logic [WORDS-1:0][63:0] b_q, b_d;
  logic [WORDS-1:0][63:0] sum_q, sum_d;
  logic                   cout_q, cout_d;
  logic                   ovf_q, ovf_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;

  logic [IW-1:0]          idx_sel_s;
  logic                   last_s;
  logic [63:0]            add_a_s, add_b_s, add_s_s;
  logic                   add_cin_s, add_cout_s;

  // Clamp the limb index into 0..WORDS-1 and flag the final limb.
  always_comb begin
    if (int'(idx_q) < WORDS) begin
      idx_sel_s = idx_q;
    end else begin
      idx_sel_s = {IW{1'b0}};
    end
    last_s = (int'(idx_q) == (WORDS - 1));
  end

  // Drive the shared adder: current limb in RUN, limb 0 otherwise.
  always_comb begin
    if (state_q == ST_RUN) begin
      add_a_s = a_q[idx_sel_s];
      add_b_s = b_q[idx_sel_s];
    end else begin
      add_a_s = a_q[0];
      add_b_s = b_q[0];
    end
    add_cin_s = carry_q;
  end

  top_module_ladner64 u_add (
    .s    (add_s_s),
    .cout (add_cout_s),
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s)
  );

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          // Subtraction becomes A + ~B + ~borrow.
          a_d     = bus.in_a;
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_d = bus.in_sub ? ~bus.in_cin : bus.in_cin;
          idx_d   = {IW{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[idx_sel_s] = add_s_s;
        carry_d          = add_cout_s;
        if (last_s) begin
          idx_d   = {IW{1'b0}};
          cout_d  = add_cout_s;
          ovf_d   = (add_a_s[63] == add_b_s[63]) && (add_s_s[63] != add_a_s[63]);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IW{1'b0}};
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= {IW{1'b0}};
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_ladner64_mp_add_seq.sv
// Self-checking bench for ladner64_mp_add_seq: directed corner cases plus
// randomized operations checked against a wide-arithmetic reference model.
module tb_ladner64_mp_add_seq;
  localparam int WORDS = 4;
  localparam int W     = 64 * WORDS;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   acc_q[$];

  ladner64_mp_add_seq_if #(.WORDS(WORDS)) bus ();

  ladner64_mp_add_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter and acceptance-edge log for the throughput check.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && rst === 1'b0) begin
      acc_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain full-width arithmetic.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
    logic [W:0]   u;
    logic [W+1:0] r;
    logic [W+1:0] ea;
    logic [W+1:0] eb;
    logic         c;
    logic         o;
    ea = {{2{a[W-1]}}, a};
    eb = {{2{b[W-1]}}, b};
    if (!sub) begin
      u = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      c = u[W];
      r = ea + eb + {{(W+1){1'b0}}, cin};
    end else begin
      u = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      c = ~u[W];
      r = ea - eb - {{(W+1){1'b0}}, cin};
    end
    o = !((r[W+1] == r[W]) && (r[W] == r[W-1]));
    return {o, c, u[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    logic [W-1:0] v;
    int k;
    k = $urandom_range(0, 6);
    v = '0;
    case (k)
      0: v = '1;
      1: v = '0;
      2: begin v = '1; v[W-1] = 1'b0; end
      3: begin v = '0; v[W-1] = 1'b1; end
      default: for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    endcase
    return v;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits for the result, checks latency/values, optionally stalls, then drains.
  task automatic collect(input string tag, input logic [W-1:0] es, input logic ec,
                         input logic eo, input int hold);
    int           lat = 0;
    logic         stable = 1'b1;
    logic [W-1:0] s0;
    logic         c0;
    logic         o0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({tag, "_lat"},  W'(lat), W'(WORDS));
    check_eq({tag, "_sum"},  bus.out_sum, es);
    check_eq({tag, "_cout"}, W'(bus.out_cout), W'(ec));
    check_eq({tag, "_ovf"},  W'(bus.out_ovf), W'(eo));
    check_eq({tag, "_rdy_done"}, W'(bus.in_ready), W'(1'b0));
    s0 = bus.out_sum; c0 = bus.out_cout; o0 = bus.out_ovf;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = h[0];
      bus.in_a     = rand_opnd();
      @(posedge clk); #1;
      if (bus.out_sum !== s0 || bus.out_cout !== c0 || bus.out_ovf !== o0 ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (hold > 0) check_eq({tag, "_hold"}, W'(stable), W'(1'b1));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_vld_after"}, W'(bus.out_valid), W'(1'b0));
    check_eq({tag, "_rdy_after"}, W'(bus.in_ready), W'(1'b1));
  endtask

  task automatic run_model(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input int hold);
    logic [W+1:0] e;
    e = ref_op(a, b, cin, sub);
    send(a, b, cin, sub);
    collect(tag, e[W-1:0], e[W], e[W+1], hold);
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] v;
    logic         never;
    int           base;
    int           t;
    ones = '1;

    // 1: reset with a pending request
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = 256'd7; bus.in_b = 256'd9;
    bus.in_cin = 1'b0; bus.in_sub = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_vld", W'(bus.out_valid), W'(1'b0));
    check_eq("rst_rdy", W'(bus.in_ready), W'(1'b1));
    check_eq("rst_sum", bus.out_sum, '0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_eq("rst_noacc_vld", W'(bus.out_valid), W'(1'b0));
    check_eq("rst_noacc_rdy", W'(bus.in_ready), W'(1'b1));

    // 2: simple add
    send(256'd1, 256'd1, 1'b0, 1'b0);
    collect("add_1_1", 256'd2, 1'b0, 1'b0, 0);

    // 3: full ripple
    send(ones, 256'd1, 1'b0, 1'b0);
    collect("ripple_c0", '0, 1'b1, 1'b0, 0);
    send(ones, 256'd1, 1'b1, 1'b0);
    collect("ripple_c1", 256'd1, 1'b1, 1'b0, 0);

    // 4: signed overflow, then borrow
    v = ones; v[W-1] = 1'b0;
    send(v, 256'd1, 1'b0, 1'b0);
    v = '0; v[W-1] = 1'b1;
    collect("ovf_pos", v, 1'b0, 1'b1, 0);
    send('0, 256'd1, 1'b0, 1'b1);
    collect("sub_0_1", ones, 1'b0, 1'b0, 0);

    // 5: limb-boundary carry with a long stall
    v = '0; v[127:64] = 64'd1;
    send({192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd1, 1'b0, 1'b0);
    collect("limb_carry", v, 1'b0, 1'b0, 10);

    // 6: reset during RUN at idx 2
    send(256'd123, 256'd456, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_rdy", W'(bus.in_ready), W'(1'b1));
    check_eq("abort_sum", bus.out_sum, '0);
    never = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) never = 1'b0;
    end
    check_eq("abort_novld", W'(never), W'(1'b1));
    send(256'd5, 256'd3, 1'b0, 1'b1);
    collect("sub_5_3", 256'd2, 1'b1, 1'b0, 0);

    // Throughput with in_valid and out_ready both held high
    base = acc_q.size();
    bus.in_a = 256'd10; bus.in_b = 256'd20; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    t = 0;
    while (acc_q.size() < base + 3 && t < 60) begin
      @(posedge clk); #1; t++;
    end
    bus.in_valid = 1'b0;
    repeat (WORDS + 4) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    if (acc_q.size() >= base + 3) begin
      check_eq("tput_0", W'(acc_q[base+1] - acc_q[base]), W'(WORDS + 2));
      check_eq("tput_1", W'(acc_q[base+2] - acc_q[base+1]), W'(WORDS + 2));
    end else begin
      check_eq("tput_timeout", W'(acc_q.size() - base), W'(3));
    end

    // Randomized operations against the reference model
    for (int n = 0; n < 24; n++) begin
      run_model($sformatf("rnd%0d", n), rand_opnd(), rand_opnd(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
